// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST controller: FSM encoding, the
// inverse-phase flag and the march data pattern.
package ram_bist_pkg;

    localparam int BIST_ADDR_W = 4;
    localparam int BIST_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR0   = 3'd1,
        S_RD0   = 3'd2,
        S_WR1   = 3'd3,
        S_RD1   = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } bist_state_e;

    // The second half of the march works on the inverted pattern.
    function automatic logic phase_inv(input bist_state_e st);
        return (st == S_WR1) || (st == S_RD1);
    endfunction

    // Base pattern: seed XOR zero-extended address.
    function automatic logic [BIST_DATA_W-1:0] bist_pattern(
        input logic [BIST_DATA_W-1:0] seed,
        input logic [BIST_ADDR_W-1:0] addr
    );
        return seed ^ {{(BIST_DATA_W-BIST_ADDR_W){1'b0}}, addr};
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-data checker: registers the expected word and address alongside each
// read, compares them against the RAM output one cycle later, and
// accumulates the sticky fail flag, first failing address and error count.
// With BIST_STOP_ON_FAIL_EN defined, a read issued in the mismatch cycle is
// dropped so that only the first mismatch is ever counted.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DATA_W = BIST_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] exp_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] dout_i,
    output logic              mismatch_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [ADDR_W+1:0] err_cnt_o
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [ADDR_W+1:0] err_cnt_q, err_cnt_d;

    assign mismatch_o = vld_q && (dout_i != exp_q);

    // Next-state for the compare pipeline and the error accumulators.
    always_comb begin
        vld_d      = rd_i && !clr_i;
        exp_d      = exp_i;
        addr_d     = addr_i;
        fail_d     = fail_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
`ifdef BIST_STOP_ON_FAIL_EN
        if (mismatch_o) vld_d = 1'b0;
`endif
        if (clr_i) begin
            fail_d     = 1'b0;
            err_addr_d = '0;
            err_cnt_d  = '0;
        end else if (mismatch_o) begin
            fail_d = 1'b1;
            if (!fail_q) err_addr_d = addr_q;
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Pipeline and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= 1'b0;
            exp_q      <= '0;
            addr_q     <= '0;
            fail_q     <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            vld_q      <= vld_d;
            exp_q      <= exp_d;
            addr_q     <= addr_d;
            fail_q     <= fail_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign fail_o     = fail_q;
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-test BIST initiator for a small single-port RAM. Runs
// write P / read P ascending / write ~P / read ~P descending, then reports.
// Optional build macro: BIST_STOP_ON_FAIL_EN (abort to DONE on first mismatch).
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DATA_W = BIST_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              ram_w_en,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W+1:0] err_cnt
);

    bist_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              clr;
    logic              is_wr;
    logic              is_rd;
    logic              mismatch;
    logic [ADDR_W-1:0] phys_addr;
    logic [DATA_W-1:0] exp_data;

    // The counter always ascends; RD1 walks the array top-down by inverting it.
    assign phys_addr = (state_q == S_RD1) ? ~cnt_q : cnt_q;
    assign exp_data  = phase_inv(state_q) ? ~bist_pattern(seed_q, phys_addr)
                                          :  bist_pattern(seed_q, phys_addr);

    // FSM next-state, address counter and phase decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        seed_d  = seed_q;
        clr     = 1'b0;
        is_wr   = 1'b0;
        is_rd   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR0;
                    seed_d  = seed;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            S_WR0: begin
                is_wr = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = S_RD0;
            end
            S_RD0: begin
                is_rd = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = S_WR1;
            end
            S_WR1: begin
                is_wr = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = S_RD1;
            end
            S_RD1: begin
                is_rd = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef BIST_STOP_ON_FAIL_EN
        if (mismatch) begin
            state_d = S_DONE;
            cnt_d   = '0;
        end
`endif
    end

    // FSM, counter and seed registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seed_q  <= seed_d;
        end
    end

    assign ram_w_en = is_wr;
    assign ram_r_en = is_rd;
    assign ram_addr = (is_wr || is_rd) ? phys_addr : '0;
    assign ram_din  = is_wr ? exp_data : '0;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .rd_i       (is_rd),
        .exp_i      (exp_data),
        .addr_i     (phys_addr),
        .dout_i     (ram_dout),
        .mismatch_o (mismatch),
        .fail_o     (fail),
        .err_addr_o (err_addr),
        .err_cnt_o  (err_cnt)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: a 16x8 registered-read RAM model with injectable
// faults sits behind the controller; directed runs with hand-derived results.
module tb_ram_bist_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic       ram_w_en;
    logic       ram_r_en;
    logic [3:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] err_addr;
    logic [5:0] err_cnt;

    logic [7:0] mem [16];
    int         fault;
    int         overlap_n;
    int         pass_n;
    int         total_n;

    ram_bist_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .seed     (seed),
        .ram_w_en (ram_w_en),
        .ram_r_en (ram_r_en),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .err_addr (err_addr),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1: bit0 stuck-at-1 at address 6; 2: bit7 stuck-at-0 everywhere.
    function automatic logic [7:0] faulty(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (fault == 1 && a == 4'h6) r[0] = 1'b1;
        if (fault == 2) r[7] = 1'b0;
        return r;
    endfunction

    // Single-port RAM model with registered read data.
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_addr] <= ram_din;
        if (ram_r_en) ram_dout <= faulty(ram_addr, mem[ram_addr]);
    end

    // Write and read enables must never be high together.
    always @(negedge clk) begin
        if (ram_w_en && ram_r_en) overlap_n <= overlap_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else pass_n++;
    endtask

    // Launch one test and observe 100 cycles; n counts edges from the one
    // that samples start. With pulse set, start is also re-asserted mid-test.
    task automatic run_bist(input logic [7:0] s, input int hold, input bit pulse,
                            output int busy_n, output int done_at, output int done_n);
        @(negedge clk);
        seed   = s;
        start  = 1'b1;
        busy_n = 0;
        done_at = -1;
        done_n = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = n;
            end
            start = (n < hold) || (pulse && (n % 7 == 0) && (n < 60));
        end
        start = 1'b0;
    endtask

    int         b_n, d_at, d_n, bad;
    logic [7:0] img;

    initial begin
        pass_n    = 0;
        total_n   = 0;
        overlap_n = 0;
        fault     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        seed      = 8'h00;
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        ram_dout  = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", {ram_w_en, ram_r_en}, 0);
        chk("rst_addr_din", {ram_addr, ram_din}, 0);
        chk("rst_err", {fail, err_addr, err_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: good RAM
        run_bist(8'hA5, 1, 1'b0, b_n, d_at, d_n);
        chk("t1_busy_cycles", b_n, 65);
        chk("t1_done_at", d_at, 66);
        chk("t1_done_count", d_n, 1);
        chk("t1_fail", fail, 0);
        chk("t1_err_cnt", err_cnt, 0);
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            img = ~(8'hA5 ^ {4'h0, a[3:0]});
            if (mem[a] !== img) bad++;
        end
        chk("t1_mem_image", bad, 0);

        // 2: bit0 stuck-at-1 at address 6; only RD0 sees it since ~P(6) has bit0 set
        fault = 1;
        run_bist(8'h00, 1, 1'b0, b_n, d_at, d_n);
        chk("t2_fail", fail, 1);
        chk("t2_err_addr", err_addr, 6);
        chk("t2_err_cnt", err_cnt, 1);
        chk("t2_done_count", d_n, 1);
`ifdef BIST_STOP_ON_FAIL_EN
        // read of addr 6 issued after edge 23, compared after edge 24, DONE after edge 25
        chk("t2_done_at", d_at, 25);
        chk("t2_busy_cycles", b_n, 24);
`else
        chk("t2_done_at", d_at, 66);
        chk("t2_busy_cycles", b_n, 65);
`endif

        // 3: bit7 stuck-at-0; every inverse read fails, RD1 descends so the
        // first failing address is the top one
        fault = 2;
        run_bist(8'h00, 1, 1'b0, b_n, d_at, d_n);
        chk("t3_fail", fail, 1);
        chk("t3_err_addr", err_addr, 15);
`ifdef BIST_STOP_ON_FAIL_EN
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_done_at", d_at, 51);
`else
        chk("t3_err_cnt", err_cnt, 16);
        chk("t3_done_at", d_at, 66);
`endif

        // 4: start held then re-pulsed during busy; restart clears errors
        fault = 0;
        run_bist(8'h5A, 30, 1'b1, b_n, d_at, d_n);
        chk("t4_done_count", d_n, 1);
        chk("t4_done_at", d_at, 66);
        chk("t4_fail", fail, 0);
        chk("t4_err_cnt", err_cnt, 0);
        chk("t4_err_addr", err_addr, 0);

        // 5: reset at cycle 20 of a test, then a clean rerun
        @(negedge clk);
        seed  = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("t5_busy_before", busy, 1);
        chk("t5_rd_before", ram_r_en, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_en_rst", {ram_w_en, ram_r_en}, 0);
        chk("t5_addr_rst", ram_addr, 0);
        @(negedge clk);
        chk("t5_idle", {busy, done}, 0);
        rst_n = 1'b1;
        run_bist(8'hC3, 1, 1'b0, b_n, d_at, d_n);
        chk("t5_busy_cycles", b_n, 65);
        chk("t5_done_at", d_at, 66);
        chk("t5_fail", fail, 0);
        chk("t5_err_cnt", err_cnt, 0);

        chk("no_rw_overlap", overlap_n, 0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
